ahmes_control: RTL and testbench

Ahmes CPU control unit: a Moore-style sequencer that fetches the opcode, decodes it and drives every datapath strobe for one instruction: PC inc/load, REM/RDM, RI, AC, flags, memory. It sits between the instruction register and the existing 8-bit PC, memory and ALU. It guarantees the PC's `inc` and `load` are never asserted together.

---
 rtl/ahmes_pkg.sv | 93 +++++++++
 rtl/ahmes_decoder.sv | 57 +++++
 rtl/ahmes_control.sv | 152 +++++++++++++++
 tb/tb_ahmes_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ahmes_pkg.sv
// Shared types and constants for the Ahmes control unit and its decoder.
package ahmes_pkg;

  // Sequencer states: idle/halted plus the eight instruction timing steps.
  typedef enum logic [3:0] {
    S_HALT,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7
  } ctrl_state_t;

  // ALU function select driven onto the datapath.
  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_NOT  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_ROR  = 4'd8,
    ALU_ROL  = 4'd9
  } alu_op_t;

  // Coarse instruction class; selects the execution path after decode.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MEM,
    CLS_UNARY,
    CLS_JUMP,
    CLS_HLT
  } instr_class_t;

  // Ahmes opcode encodings.
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_STA = 8'h10;
  localparam logic [7:0] OP_LDA = 8'h20;
  localparam logic [7:0] OP_ADD = 8'h30;
  localparam logic [7:0] OP_OR  = 8'h40;
  localparam logic [7:0] OP_AND = 8'h50;
  localparam logic [7:0] OP_NOT = 8'h60;
  localparam logic [7:0] OP_SUB = 8'h70;
  localparam logic [7:0] OP_JMP = 8'h80;
  localparam logic [7:0] OP_JN  = 8'h90;
  localparam logic [7:0] OP_JP  = 8'h94;
  localparam logic [7:0] OP_JV  = 8'h98;
  localparam logic [7:0] OP_JNV = 8'h9C;
  localparam logic [7:0] OP_JZ  = 8'hA0;
  localparam logic [7:0] OP_JNZ = 8'hA4;
  localparam logic [7:0] OP_JC  = 8'hB0;
  localparam logic [7:0] OP_JNC = 8'hB4;
  localparam logic [7:0] OP_JB  = 8'hB8;
  localparam logic [7:0] OP_JNB = 8'hBC;
  localparam logic [7:0] OP_SHR = 8'hE0;
  localparam logic [7:0] OP_SHL = 8'hE1;
  localparam logic [7:0] OP_ROR = 8'hE2;
  localparam logic [7:0] OP_ROL = 8'hE3;
  localparam logic [7:0] OP_HLT = 8'hF0;

  // Flag register update enables.
  typedef struct packed {
    logic nz;
    logic c;
    logic v;
    logic b;
  } flag_en_t;

  // Which flags an ALU result updates; LDA uses PASS and only touches N/Z.
  function automatic flag_en_t flag_enables(alu_op_t op);
    flag_en_t f;
    f = '{nz: 1'b1, c: 1'b0, v: 1'b0, b: 1'b0};
    case (op)
      ALU_ADD: begin
        f.c = 1'b1;
        f.v = 1'b1;
      end
      ALU_SUB: begin
        f.b = 1'b1;
        f.v = 1'b1;
      end
      ALU_SHR, ALU_SHL, ALU_ROR, ALU_ROL: f.c = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ahmes_decoder.sv
// Combinational opcode decoder: classifies the instruction in RI, picks the
// ALU function and evaluates the branch condition against the current flags.
module ahmes_decoder
  import ahmes_pkg::*;
(
  input  logic         [7:0] ri,
  input  logic               flag_n,
  input  logic               flag_z,
  input  logic               flag_v,
  input  logic               flag_c,
  input  logic               flag_b,
  output instr_class_t       instr_class,
  output alu_op_t            alu_op,
  output logic               is_store,
  output logic               jump_taken
);

  // Jumps and shifts match the whole byte; everything else matches only the
  // high nibble, and anything unrecognised falls through as a NOP.
  always_comb begin
    instr_class = CLS_NOP;
    alu_op      = ALU_PASS;
    is_store    = 1'b0;
    jump_taken  = 1'b0;
    case (ri)
      OP_JMP: begin instr_class = CLS_JUMP; jump_taken = 1'b1;    end
      OP_JN:  begin instr_class = CLS_JUMP; jump_taken = flag_n;  end
      OP_JP:  begin instr_class = CLS_JUMP; jump_taken = !flag_n; end
      OP_JV:  begin instr_class = CLS_JUMP; jump_taken = flag_v;  end
      OP_JNV: begin instr_class = CLS_JUMP; jump_taken = !flag_v; end
      OP_JZ:  begin instr_class = CLS_JUMP; jump_taken = flag_z;  end
      OP_JNZ: begin instr_class = CLS_JUMP; jump_taken = !flag_z; end
      OP_JC:  begin instr_class = CLS_JUMP; jump_taken = flag_c;  end
      OP_JNC: begin instr_class = CLS_JUMP; jump_taken = !flag_c; end
      OP_JB:  begin instr_class = CLS_JUMP; jump_taken = flag_b;  end
      OP_JNB: begin instr_class = CLS_JUMP; jump_taken = !flag_b; end
      OP_SHR: begin instr_class = CLS_UNARY; alu_op = ALU_SHR; end
      OP_SHL: begin instr_class = CLS_UNARY; alu_op = ALU_SHL; end
      OP_ROR: begin instr_class = CLS_UNARY; alu_op = ALU_ROR; end
      OP_ROL: begin instr_class = CLS_UNARY; alu_op = ALU_ROL; end
      default: begin
        case (ri[7:4])
          OP_STA[7:4]: begin instr_class = CLS_MEM; is_store = 1'b1; end
          OP_LDA[7:4]: begin instr_class = CLS_MEM; alu_op = ALU_PASS; end
          OP_ADD[7:4]: begin instr_class = CLS_MEM; alu_op = ALU_ADD;  end
          OP_OR[7:4]:  begin instr_class = CLS_MEM; alu_op = ALU_OR;   end
          OP_AND[7:4]: begin instr_class = CLS_MEM; alu_op = ALU_AND;  end
          OP_SUB[7:4]: begin instr_class = CLS_MEM; alu_op = ALU_SUB;  end
          OP_NOT[7:4]: begin instr_class = CLS_UNARY; alu_op = ALU_NOT; end
          OP_HLT[7:4]: instr_class = CLS_HLT;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ahmes_control.sv
// Ahmes control unit: Moore sequencer driving every datapath strobe for
// fetch, decode and execute. Outputs depend only on state, RI and flags.
module ahmes_control
  import ahmes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] ri,
  input  logic       flag_n,
  input  logic       flag_z,
  input  logic       flag_v,
  input  logic       flag_c,
  input  logic       flag_b,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       rem_load,
  output logic       rem_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ri_load,
  output logic       ac_load,
  output logic [3:0] alu_op,
  output logic       nz_load,
  output logic       c_load,
  output logic       v_load,
  output logic       b_load,
  output logic       halted
);

  ctrl_state_t  state, state_next;
  instr_class_t dec_class;
  alu_op_t      dec_alu, alu_op_c;
  logic         dec_store, dec_taken;
  flag_en_t     flag_en;

  ahmes_decoder u_decoder (
    .ri          (ri),
    .flag_n      (flag_n),
    .flag_z      (flag_z),
    .flag_v      (flag_v),
    .flag_c      (flag_c),
    .flag_b      (flag_b),
    .instr_class (dec_class),
    .alu_op      (dec_alu),
    .is_store    (dec_store),
    .jump_taken  (dec_taken)
  );

  assign alu_op  = alu_op_c;
  assign nz_load = flag_en.nz;
  assign c_load  = flag_en.c;
  assign v_load  = flag_en.v;
  assign b_load  = flag_en.b;

  // State register; reset abandons any partial instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_HALT;
    else       state <= state_next;
  end

  // Next-state and strobe decode. PC inc and load live in disjoint steps.
  always_comb begin
    state_next = state;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    rem_load   = 1'b0;
    rem_sel    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ri_load    = 1'b0;
    ac_load    = 1'b0;
    alu_op_c   = ALU_PASS;
    flag_en    = '0;
    halted     = 1'b0;
    case (state)
      S_HALT: begin
        halted = 1'b1;
        if (run) state_next = S_T0;
      end
      S_T0: begin
        rem_load   = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        mem_read   = 1'b1;
        pc_inc     = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        ri_load    = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        state_next = S_T0;
        case (dec_class)
          CLS_UNARY: begin
            ac_load  = 1'b1;
            alu_op_c = dec_alu;
            flag_en  = flag_enables(dec_alu);
          end
          CLS_HLT: state_next = S_HALT;
          CLS_JUMP: begin
            if (dec_taken) begin
              rem_load   = 1'b1;
              state_next = S_T4;
            end else begin
              pc_inc = 1'b1;
            end
          end
          CLS_MEM: begin
            rem_load   = 1'b1;
            state_next = S_T4;
          end
          default: ;
        endcase
      end
      S_T4: begin
        mem_read   = 1'b1;
        pc_inc     = (dec_class == CLS_MEM);
        state_next = S_T5;
      end
      S_T5: begin
        if (dec_class == CLS_MEM) begin
          rem_load   = 1'b1;
          rem_sel    = 1'b1;
          state_next = S_T6;
        end else begin
          pc_load    = 1'b1;
          state_next = S_T0;
        end
      end
      S_T6: begin
        if (dec_store) begin
          mem_write  = 1'b1;
          state_next = S_T0;
        end else begin
          mem_read   = 1'b1;
          state_next = S_T7;
        end
      end
      S_T7: begin
        ac_load    = 1'b1;
        alu_op_c   = dec_alu;
        flag_en    = flag_enables(dec_alu);
        state_next = S_T0;
      end
      default: state_next = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_ahmes_control.sv
// Directed bench for ahmes_control: walks instructions step by step and
// compares the full output vector against hand-computed values.
module tb_ahmes_control;
  import ahmes_pkg::*;

  localparam logic [12:0] B_PCINC  = 13'h1000;
  localparam logic [12:0] B_PCLOAD = 13'h0800;
  localparam logic [12:0] B_REMLD  = 13'h0400;
  localparam logic [12:0] B_REMSEL = 13'h0200;
  localparam logic [12:0] B_MRD    = 13'h0100;
  localparam logic [12:0] B_MWR    = 13'h0080;
  localparam logic [12:0] B_RILD   = 13'h0040;
  localparam logic [12:0] B_ACLD   = 13'h0020;
  localparam logic [12:0] B_NZ     = 13'h0010;
  localparam logic [12:0] B_C      = 13'h0008;
  localparam logic [12:0] B_V      = 13'h0004;
  localparam logic [12:0] B_B      = 13'h0002;
  localparam logic [12:0] B_HALT   = 13'h0001;

  logic       clk, reset, run;
  logic [7:0] ri;
  logic       flag_n, flag_z, flag_v, flag_c, flag_b;
  logic       pc_inc, pc_load, rem_load, rem_sel, mem_read, mem_write;
  logic       ri_load, ac_load, nz_load, c_load, v_load, b_load, halted;
  logic [3:0] alu_op;
  logic [16:0] out_vec;
  int err_count = 0;
  int check_count = 0;

  ahmes_control dut (
    .clk(clk), .reset(reset), .run(run), .ri(ri),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c), .flag_b(flag_b),
    .pc_inc(pc_inc), .pc_load(pc_load), .rem_load(rem_load), .rem_sel(rem_sel),
    .mem_read(mem_read), .mem_write(mem_write), .ri_load(ri_load), .ac_load(ac_load),
    .alu_op(alu_op), .nz_load(nz_load), .c_load(c_load), .v_load(v_load),
    .b_load(b_load), .halted(halted)
  );

  assign out_vec = {alu_op, pc_inc, pc_load, rem_load, rem_sel, mem_read, mem_write,
                    ri_load, ac_load, nz_load, c_load, v_load, b_load, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exclusive-strobe invariants, checked every cycle away from the edge.
  always @(negedge clk) begin
    check_count++;
    assert ((pc_inc & pc_load) === 1'b0) else begin
      err_count++;
      $error("[TB] FAIL pc_excl: observed=%b required=0", pc_inc & pc_load);
    end
    check_count++;
    assert ((mem_read & mem_write) === 1'b0) else begin
      err_count++;
      $error("[TB] FAIL mem_excl: observed=%b required=0", mem_read & mem_write);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input alu_op_t op, input logic [12:0] strobes);
    logic [16:0] expv;
    expv = {op, strobes};
    check_count++;
    assert (out_vec === expv) else begin
      err_count++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, out_vec, expv);
    end
  endtask

  // From a checked T0: set the opcode, step through T1/T2 and land in T3.
  task automatic apply_stimulus(input string name, input logic [7:0] opcode);
    ri = opcode;
    tick(); check_output({name, " T1"}, ALU_PASS, B_PCINC | B_MRD);
    tick(); check_output({name, " T2"}, ALU_PASS, B_RILD);
    tick();
  endtask

  // Memory-operand steps T3..T6 for a non-store instruction.
  task automatic mem_read_path(input string name);
    check_output({name, " T3"}, ALU_PASS, B_REMLD);
    tick(); check_output({name, " T4"}, ALU_PASS, B_MRD | B_PCINC);
    tick(); check_output({name, " T5"}, ALU_PASS, B_REMLD | B_REMSEL);
    tick(); check_output({name, " T6"}, ALU_PASS, B_MRD);
    tick();
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; ri = 8'h00;
    flag_n = 1'b0; flag_z = 1'b0; flag_v = 1'b0; flag_c = 1'b0; flag_b = 1'b0;
    #1;
    check_output("reset_async", ALU_PASS, B_HALT);
    tick(); tick();
    reset = 1'b0;
    check_output("reset_state", ALU_PASS, B_HALT);
    tick();
    check_output("halt_no_run", ALU_PASS, B_HALT);
    run = 1'b1;
    check_output("halt_run_cycle", ALU_PASS, B_HALT);
    tick();
    run = 1'b0;
    check_output("first_T0", ALU_PASS, B_REMLD);

    // NOP: one PC increment, back to T0 four cycles after leaving T0
    apply_stimulus("nop", OP_NOP);
    check_output("nop T3", ALU_PASS, '0);
    tick(); check_output("nop ret T0", ALU_PASS, B_REMLD);

    // LDA, with run held high to show it is ignored outside halt
    run = 1'b1;
    apply_stimulus("lda", OP_LDA);
    mem_read_path("lda");
    check_output("lda T7", ALU_PASS, B_ACLD | B_NZ);
    tick(); check_output("lda ret T0", ALU_PASS, B_REMLD);
    run = 1'b0;

    // STA: write in T6, no AC update, 7 cycles
    apply_stimulus("sta", OP_STA);
    check_output("sta T3", ALU_PASS, B_REMLD);
    tick(); check_output("sta T4", ALU_PASS, B_MRD | B_PCINC);
    tick(); check_output("sta T5", ALU_PASS, B_REMLD | B_REMSEL);
    tick(); check_output("sta T6", ALU_PASS, B_MWR);
    tick(); check_output("sta ret T0", ALU_PASS, B_REMLD);

    // SUB: full memory path with borrow/overflow enables
    apply_stimulus("sub", OP_SUB);
    mem_read_path("sub");
    check_output("sub T7", ALU_SUB, B_ACLD | B_NZ | B_B | B_V);
    tick(); check_output("sub ret T0", ALU_PASS, B_REMLD);

    // JZ taken
    flag_z = 1'b1;
    apply_stimulus("jz_t", OP_JZ);
    check_output("jz_t T3", ALU_PASS, B_REMLD);
    tick(); check_output("jz_t T4", ALU_PASS, B_MRD);
    tick(); check_output("jz_t T5", ALU_PASS, B_PCLOAD);
    tick(); check_output("jz_t ret T0", ALU_PASS, B_REMLD);

    // JZ not taken
    flag_z = 1'b0;
    apply_stimulus("jz_nt", OP_JZ);
    check_output("jz_nt T3", ALU_PASS, B_PCINC);
    tick(); check_output("jz_nt ret T0", ALU_PASS, B_REMLD);

    // JP taken because N is clear
    apply_stimulus("jp_t", OP_JP);
    check_output("jp_t T3", ALU_PASS, B_REMLD);
    tick(); check_output("jp_t T4", ALU_PASS, B_MRD);
    tick(); check_output("jp_t T5", ALU_PASS, B_PCLOAD);
    tick(); check_output("jp_t ret T0", ALU_PASS, B_REMLD);

    // JNC not taken because C is set
    flag_c = 1'b1;
    apply_stimulus("jnc_nt", OP_JNC);
    check_output("jnc_nt T3", ALU_PASS, B_PCINC);
    tick(); check_output("jnc_nt ret T0", ALU_PASS, B_REMLD);
    flag_c = 1'b0;

    // SHL and NOT complete in T3
    apply_stimulus("shl", OP_SHL);
    check_output("shl T3", ALU_SHL, B_ACLD | B_NZ | B_C);
    tick(); check_output("shl ret T0", ALU_PASS, B_REMLD);
    apply_stimulus("not", OP_NOT);
    check_output("not T3", ALU_NOT, B_ACLD | B_NZ);
    tick(); check_output("not ret T0", ALU_PASS, B_REMLD);

    // Undefined opcodes: 0x81 (near JMP) and 0xE4 (near shifts) act as NOP
    apply_stimulus("undef81", 8'h81);
    check_output("undef81 T3", ALU_PASS, '0);
    tick(); check_output("undef81 ret T0", ALU_PASS, B_REMLD);
    apply_stimulus("undefE4", 8'hE4);
    check_output("undefE4 T3", ALU_PASS, '0);
    tick(); check_output("undefE4 ret T0", ALU_PASS, B_REMLD);

    // HLT (0xF7 in the HLT range): halt and stay halted without run
    apply_stimulus("hlt", 8'hF7);
    check_output("hlt T3", ALU_PASS, '0);
    tick(); check_output("hlt halted", ALU_PASS, B_HALT);
    tick(); check_output("hlt stays 1", ALU_PASS, B_HALT);
    tick(); check_output("hlt stays 2", ALU_PASS, B_HALT);

    // Restart and abandon ADD with a reset in T4
    run = 1'b1;
    tick();
    run = 1'b0;
    check_output("restart T0", ALU_PASS, B_REMLD);
    apply_stimulus("add", OP_ADD);
    check_output("add T3", ALU_PASS, B_REMLD);
    tick(); check_output("add T4", ALU_PASS, B_MRD | B_PCINC);
    #2;
    reset = 1'b1;
    #1;
    check_output("add reset async", ALU_PASS, B_HALT);
    tick(); check_output("add reset held", ALU_PASS, B_HALT);
    reset = 1'b0;
    tick(); check_output("add after reset", ALU_PASS, B_HALT);
    tick(); check_output("add no ac_load", ALU_PASS, B_HALT);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
